// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration arbiter.
// Word layout is {slave, sub-address, data}, 8 bits each.
package i2c_cfg_pkg;

   localparam int I2C_WORD_W = 24;
   localparam logic [7:0] AUD_ADDR = 8'h34;
   localparam logic [7:0] VID_ADDR = 8'h40;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARB      = 3'd1,
      ST_LAUNCH   = 3'd2,
      ST_WAIT_END = 3'd3,
      ST_DROP     = 3'd4,
      ST_DONE     = 3'd5
   } cfgState_t;

   // Counter width helper that never returns zero.
   function automatic int clogb(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Work-clock divider: toggles oCLK every DIV iCLK cycles.
// oFallEvt marks the iCLK cycle whose edge takes oCLK from 1 to 0.
module i2c_clk_div
   import i2c_cfg_pkg::*;
#(
   parameter int DIV = 1250
)(
   input  logic iCLK,
   input  logic iRST,
   output logic oCLK,
   output logic oFallEvt
);

   localparam int DV = (DIV > 0) ? DIV : 1;
   localparam int CW = clogb(DV);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap     = (cnt == CW'(DV - 1));
   assign oFallEvt = wrap & oCLK;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt  <= '0;
         oCLK <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         oCLK <= ~oCLK;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_cfg_arbiter.sv
// Round-robin front end sharing one I2C_Controller among N_REQ requesters,
// with NACK retry, timeout recovery and per-requester completion pulses.
module i2c_cfg_arbiter
   import i2c_cfg_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int CLK_FREQ  = 50000000,
   parameter int I2C_FREQ  = 20000,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 65535
)(
   input  logic                        iCLK,
   input  logic                        iRST,
   input  logic [N_REQ-1:0]            iREQ,
   input  logic [I2C_WORD_W*N_REQ-1:0] iREQ_DATA,
   output logic [N_REQ-1:0]            oDONE,
   output logic [N_REQ-1:0]            oERR,
   output logic                        oBUSY,
   output logic                        oI2C_CTRL_CLK,
   output logic [I2C_WORD_W-1:0]       oI2C_DATA,
   output logic                        oI2C_GO,
   input  logic                        iI2C_END,
   input  logic                        iI2C_ACK
);

   localparam int DIV  = CLK_FREQ / (2 * I2C_FREQ);
   localparam int HOLD = 4 * ((DIV > 0) ? DIV : 1);
   localparam int TMAX = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
   localparam int TW   = clogb(TMAX + 1);
   localparam int RW   = clogb(N_REQ);
   localparam int XW   = clogb(MAX_RETRY + 1);

   cfgState_t             state;
   logic [RW-1:0]         rr;
   logic [RW-1:0]         grant;
   logic [RW-1:0]         nxtGnt;
   logic                  found;
   logic [RW-1:0]         cand;
   int                    rrIdx;
   logic [I2C_WORD_W-1:0] word;
   logic [I2C_WORD_W-1:0] nxtWord;
   logic [XW-1:0]         retry;
   logic [TW-1:0]         timer;
   logic                  isErr;
   logic                  toErr;
   logic                  reLaunch;
   logic                  goLow;
   logic                  fallEvt;
   logic                  endS1, endS, endD;
   logic                  ackS1, ackS;
   logic                  endRise;
   logic                  toHit;
   logic                  dropDone;

   i2c_clk_div #(
      .DIV      (DIV)
   ) uDiv (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .oCLK     (oI2C_CTRL_CLK),
      .oFallEvt (fallEvt)
   );

   // END/ACK come from the work-clock domain.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         endS1 <= 1'b0;
         endS  <= 1'b0;
         endD  <= 1'b0;
         ackS1 <= 1'b0;
         ackS  <= 1'b0;
      end else begin
         endS1 <= iI2C_END;
         endS  <= endS1;
         endD  <= endS;
         ackS1 <= iI2C_ACK;
         ackS  <= ackS1;
      end
   end

   assign endRise = endS & ~endD;
   assign toHit   = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

   always_comb begin
      nxtGnt = rr;
      found  = 1'b0;
      rrIdx  = 0;
      cand   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         rrIdx = (int'(rr) + k) % N_REQ;
         cand  = RW'(rrIdx);
         if (!found && iREQ[cand]) begin
            found  = 1'b1;
            nxtGnt = cand;
         end
      end
   end

   always_comb begin
      nxtWord = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (RW'(i) == nxtGnt)
            nxtWord = iREQ_DATA[i*I2C_WORD_W +: I2C_WORD_W];
      end
   end

   // Timeout recovery ignores END; normal recovery waits for re-arm.
   assign dropDone = toErr ? (timer == TW'(HOLD - 1)) : !endS;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= ST_IDLE;
         rr        <= RW'(N_REQ - 1);
         grant     <= '0;
         word      <= '0;
         retry     <= '0;
         timer     <= '0;
         isErr     <= 1'b0;
         toErr     <= 1'b0;
         reLaunch  <= 1'b0;
         goLow     <= 1'b0;
         oI2C_DATA <= '0;
         oI2C_GO   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (|iREQ)
                  state <= ST_ARB;
            end
            ST_ARB: begin
               if (found) begin
                  grant <= nxtGnt;
                  rr    <= nxtGnt;
                  word  <= nxtWord;
                  retry <= '0;
                  state <= ST_LAUNCH;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               if (fallEvt) begin
                  oI2C_DATA <= word;
                  oI2C_GO   <= 1'b1;
                  timer     <= '0;
                  state     <= ST_WAIT_END;
               end
            end
            ST_WAIT_END: begin
               timer <= timer + 1'b1;
               if (endRise) begin
                  toErr <= 1'b0;
                  goLow <= 1'b0;
                  state <= ST_DROP;
                  if (!ackS) begin
                     isErr    <= 1'b0;
                     reLaunch <= 1'b0;
                  end else if (retry < XW'(MAX_RETRY)) begin
                     retry    <= retry + 1'b1;
                     isErr    <= 1'b0;
                     reLaunch <= 1'b1;
                  end else begin
                     isErr    <= 1'b1;
                     reLaunch <= 1'b0;
                  end
               end else if (toHit) begin
                  isErr    <= 1'b1;
                  toErr    <= 1'b1;
                  reLaunch <= 1'b0;
                  goLow    <= 1'b0;
                  state    <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (!goLow) begin
                  if (fallEvt) begin
                     oI2C_GO <= 1'b0;
                     goLow   <= 1'b1;
                     timer   <= '0;
                  end
               end else begin
                  timer <= timer + 1'b1;
                  if (dropDone) begin
                     goLow <= 1'b0;
                     state <= reLaunch ? ST_LAUNCH : ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      oDONE = '0;
      oERR  = '0;
      if (state == ST_DONE) begin
         oDONE[grant] = 1'b1;
         oERR[grant]  = isErr;
      end
   end

   assign oBUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Scoreboard bench for i2c_cfg_arbiter with a behavioural controller model.
// Expected GO words and completions are queued at stimulus time.
module tb_i2c_cfg_arbiter;
   import i2c_cfg_pkg::*;

   logic          clk = 1'b0;
   logic          iRST;
   logic [2:0]    iREQ;
   logic [71:0]   iREQ_DATA;
   logic [2:0]    oDONE;
   logic [2:0]    oERR;
   logic          oBUSY;
   logic          oI2C_CTRL_CLK;
   logic [23:0]   oI2C_DATA;
   logic          oI2C_GO;
   logic          iI2C_END = 1'b0;
   logic          iI2C_ACK = 1'b0;

   typedef struct {
      int idx;
      bit err;
   } doneExp_t;

   doneExp_t    expDoneQ[$];
   logic [23:0] expGoQ[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int goCount = 0;
   int goRiseCyc = 0;
   int lastDoneCyc = 0;
   int nackLeft = 0;
   bit hang = 1'b0;
   int mCnt = 0;
   logic goPrev = 1'b0;

   i2c_cfg_arbiter #(
      .N_REQ     (3),
      .CLK_FREQ  (1000),
      .I2C_FREQ  (100),
      .MAX_RETRY (3),
      .TIMEOUT   (1000)
   ) dut (
      .iCLK          (clk),
      .iRST          (iRST),
      .iREQ          (iREQ),
      .iREQ_DATA     (iREQ_DATA),
      .oDONE         (oDONE),
      .oERR          (oERR),
      .oBUSY         (oBUSY),
      .oI2C_CTRL_CLK (oI2C_CTRL_CLK),
      .oI2C_DATA     (oI2C_DATA),
      .oI2C_GO       (oI2C_GO),
      .iI2C_END      (iI2C_END),
      .iI2C_ACK      (iI2C_ACK)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Controller model: END rises 30 work clocks after GO, cleared by GO low.
   always @(posedge oI2C_CTRL_CLK) begin
      if (!oI2C_GO) begin
         mCnt = 0;
         iI2C_END <= 1'b0;
      end else if (!hang && !iI2C_END) begin
         mCnt++;
         if (mCnt == 30) begin
            iI2C_END <= 1'b1;
            iI2C_ACK <= (nackLeft > 0);
            if (nackLeft > 0) nackLeft--;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Monitor: GO rising edges and completion pulses.
   always @(negedge clk) begin
      doneExp_t   e;
      logic [2:0] expV;
      logic [23:0] w;
      if (oI2C_GO && !goPrev) begin
         goCount++;
         goRiseCyc = cyc;
         if (expGoQ.size() == 0) begin
            check("unexpected_go", 32'(oI2C_DATA), 32'hFFFFFFFF);
         end else begin
            w = expGoQ.pop_front();
            check("go_data", 32'(oI2C_DATA), 32'(w));
         end
      end
      goPrev = oI2C_GO;
      if (|oDONE) begin
         if (expDoneQ.size() == 0) begin
            check("unexpected_done", 32'(oDONE), 32'h0);
         end else begin
            e = expDoneQ.pop_front();
            expV = 3'b001 << e.idx;
            check("done_vec", 32'(oDONE), 32'(expV));
            check("done_err", 32'(oERR), e.err ? 32'(expV) : 32'h0);
         end
      end
   end

   task automatic waitDone(input int maxCyc, output int who);
      int n = 0;
      who = -1;
      do begin
         @(negedge clk);
         n++;
      end while (!(|oDONE) && n < maxCyc);
      if (|oDONE) begin
         lastDoneCyc = cyc;
         for (int i = 0; i < 3; i++) if (oDONE[i]) who = i;
      end else begin
         tests++;
         fails++;
         $display("FAIL done_timeout: no oDONE within %0d cycles", maxCyc);
      end
   endtask

   task automatic waitGo(input int maxCyc);
      int n = 0;
      while (!oI2C_GO && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      check("go_seen", 32'(oI2C_GO), 32'h1);
   endtask

   task automatic doReset();
      @(negedge clk);
      iRST = 1'b1;
      repeat (2) @(negedge clk);
      iRST = 1'b0;
   endtask

   logic [23:0] w2 [3][2];
   int who, g0, d;
   int served [3];

   initial begin
      iRST = 1'b1;
      iREQ = '0;
      iREQ_DATA = '0;
      repeat (3) @(negedge clk);
      check("rst_done", 32'(oDONE), 0);
      check("rst_err", 32'(oERR), 0);
      check("rst_busy", 32'(oBUSY), 0);
      check("rst_clk", 32'(oI2C_CTRL_CLK), 0);
      check("rst_data", 32'(oI2C_DATA), 0);
      check("rst_go", 32'(oI2C_GO), 0);
      iRST = 1'b0;

      // 1) single request
      expGoQ.push_back({AUD_ADDR, 16'h0017});
      expDoneQ.push_back('{0, 1'b0});
      g0 = goCount;
      iREQ_DATA[23:0] = {AUD_ADDR, 16'h0017};
      iREQ = 3'b001;
      repeat (3) @(negedge clk);
      check("t1_busy", 32'(oBUSY), 1);
      waitDone(2000, who);
      iREQ = '0;
      check("t1_go_cnt", 32'(goCount - g0), 1);

      // 2) all requesters, two words each, from fresh rr
      doReset();
      w2[0][0] = 24'h340010; w2[0][1] = 24'h340012;
      w2[1][0] = 24'h401234; w2[1][1] = 24'h405678;
      w2[2][0] = 24'h3403AA; w2[2][1] = 24'h3405BB;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++) begin
            expGoQ.push_back(w2[i][r]);
            expDoneQ.push_back('{i, 1'b0});
         end
      for (int i = 0; i < 3; i++) begin
         served[i] = 0;
         iREQ_DATA[i*24 +: 24] = w2[i][0];
      end
      iREQ = 3'b111;
      for (int k = 0; k < 6; k++) begin
         waitDone(2000, who);
         if (who >= 0) begin
            served[who]++;
            if (served[who] >= 2) iREQ[who] = 1'b0;
            else iREQ_DATA[who*24 +: 24] = w2[who][1];
         end
      end
      iREQ = '0;

      // 3) NACK every attempt on requester 1
      repeat (5) @(negedge clk);
      nackLeft = 4;
      for (int i = 0; i < 4; i++) expGoQ.push_back({VID_ADDR, 16'h0A55});
      expDoneQ.push_back('{1, 1'b1});
      g0 = goCount;
      iREQ_DATA[47:24] = {VID_ADDR, 16'h0A55};
      iREQ = 3'b010;
      waitDone(4000, who);
      iREQ = '0;
      check("t3_go_cnt", 32'(goCount - g0), 4);

      // 4) NACK twice then ACK on requester 2
      repeat (5) @(negedge clk);
      nackLeft = 2;
      for (int i = 0; i < 3; i++) expGoQ.push_back({AUD_ADDR, 16'h0C79});
      expDoneQ.push_back('{2, 1'b0});
      g0 = goCount;
      iREQ_DATA[71:48] = {AUD_ADDR, 16'h0C79};
      iREQ = 3'b100;
      waitDone(4000, who);
      iREQ = '0;
      check("t4_go_cnt", 32'(goCount - g0), 3);

      // 5) hung controller, then normal service
      repeat (5) @(negedge clk);
      hang = 1'b1;
      expGoQ.push_back(24'h341E00);
      expDoneQ.push_back('{0, 1'b1});
      iREQ_DATA[23:0] = 24'h341E00;
      iREQ = 3'b001;
      waitDone(3000, who);
      iREQ = '0;
      check("t5_go_low", 32'(oI2C_GO), 0);
      d = lastDoneCyc - goRiseCyc;
      tests++;
      if (d < 1000 || d > 1050) begin
         fails++;
         $display("FAIL t5_latency: got %0d cycles, want 1000..1050", d);
      end
      hang = 1'b0;
      repeat (5) @(negedge clk);
      expGoQ.push_back(24'h400C33);
      expDoneQ.push_back('{1, 1'b0});
      iREQ_DATA[47:24] = 24'h400C33;
      iREQ = 3'b010;
      waitDone(2000, who);
      iREQ = '0;

      // 6) reset during WAIT_END
      repeat (5) @(negedge clk);
      expGoQ.push_back(24'h40AB01);
      iREQ_DATA[47:24] = 24'h40AB01;
      iREQ = 3'b010;
      waitGo(500);
      repeat (50) @(negedge clk);
      iRST = 1'b1;
      iREQ = 3'b100;
      iREQ_DATA[71:48] = 24'h34C0DE;
      @(negedge clk);
      check("t6_done", 32'(oDONE), 0);
      check("t6_err", 32'(oERR), 0);
      check("t6_busy", 32'(oBUSY), 0);
      check("t6_clk", 32'(oI2C_CTRL_CLK), 0);
      check("t6_data", 32'(oI2C_DATA), 0);
      check("t6_go", 32'(oI2C_GO), 0);
      expGoQ.push_back(24'h34C0DE);
      expDoneQ.push_back('{2, 1'b0});
      @(negedge clk);
      iRST = 1'b0;
      waitDone(2000, who);
      iREQ = '0;
      check("t6_who", 32'(who), 2);

      repeat (20) @(negedge clk);
      check("go_q_empty", 32'(expGoQ.size()), 0);
      check("done_q_empty", 32'(expDoneQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
